fpu_d_sched: RTL
================

# fpu_d_sched

Two-port scheduler that shares one combinational double-precision FPU (FADD.D/FSUB.D/FMUL.D/FDIV.D, selected by funct3) between two requesters, for example the integer pipeline and the custom-instruction coprocessor port. It arbitrates round-robin and registers the winning operands. It holds them stable on the FPU inputs for a per-operation multicycle settle window, captures the result and returns it with the requester ID and destination register. Only one operation is in flight at a time.

## Interface
Parameters:
- LAT_ADD, 2, settle cycles for funct3 000/001 (legal range 1..255)
- LAT_MUL, 4, settle cycles for funct3 010 (legal range 1..255)
- LAT_DIV, 16, settle cycles for funct3 011 (legal range 1..255)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  (N=0,1) requester N presents an operation
- reqN_ready  out  1  operation accepted on this cycle when reqN_valid is also high
- reqN_rs1, reqN_rs2  in  64 each  IEEE-754 double operands
- reqN_funct3  in  3  operation select
- reqN_rd  in  5  destination tag, returned unchanged
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that issued the operation
- rsp_rd  out  5  echoed rd
- rsp_result  out  64  captured FPU result
- rsp_illegal  out  1  funct3 was 1xx; rsp_result is 0
- fpu_rs1, fpu_rs2  out  64 each  registered operands to the FPU
- fpu_funct3  out  3  registered operation select to the FPU
- fpu_result  in  64  FPU combinational result
- busy  out  1  high whenever the state is not IDLE

## Operation
- The controller has three states: IDLE, EXEC and RESP.
- **Arbitration in IDLE.**
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester selected by the rr pointer is granted.
  - reqN_ready = (state==IDLE) & grantN. ready may depend on valid.
  - At most one ready is high per cycle.
- **rr pointer.**
  - Resets to 0.
  - On each accepted request from requester i, rr becomes ~i.
  - rr does not change when no request is accepted.
- **Accept (valid & ready).**
  - Capture rs1, rs2, funct3, rd and id into the operand registers.
  - fpu_* outputs come directly from these registers and stay stable until the next accept.
- **Legal funct3 (0xx).**
  - The countdown cnt loads LAT_x − 1 and the state moves to EXEC.
  - LAT_x is LAT_ADD for 000/001, LAT_MUL for 010 and LAT_DIV for 011.
- **Illegal funct3 (1xx).**
  - The state moves directly to RESP.
  - rsp_illegal=1, rsp_result=0.
- **EXEC.**
  - cnt decrements each cycle.
  - In the cycle where cnt==0, rsp_result captures fpu_result, rsp_illegal is set to 0 and the state moves to RESP.
- **RESP.**
  - rsp_valid=1. rsp_id, rsp_rd, rsp_result and rsp_illegal are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, the state returns to IDLE.
  - No request is accepted in the handshake cycle itself.
- **cnt width** is 8 bits. Other LAT values outside 1..255 are unsupported.

## Timing
- **Reset values.** State=IDLE, rr=0, cnt=0.
  - reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_rd=0, rsp_result=0, rsp_illegal=0.
  - fpu_rs1=0, fpu_rs2=0, fpu_funct3=0, busy=0.
- **Latency, legal op.** Accept in cycle T; EXEC occupies cycles T+1..T+LAT; rsp_valid is first high in cycle T+LAT+1.
- **Latency, illegal op.** rsp_valid is first high in cycle T+1.
- **Throughput.** With rsp_ready tied high, the next accept can happen in the cycle after the response handshake. This gives a minimum of LAT+2 cycles per legal op.
- **rsp_ready stall.** The response holds indefinitely. No new accept happens and both readys stay low.
- **Requester dropping valid.** If reqN_valid drops before it is granted, nothing happens and rr is unchanged.
- **Reset mid-operation.** rst in any state returns every output to its reset value on the next edge. The in-flight operation is discarded and no response is issued.
- **rst dominance.** rst overrides a simultaneous accept or response handshake.

## Test plan
The bench replaces the FPU with a stub: fpu_result = fpu_rs1 ^ fpu_rs2.

- **Single legal op.** req0 FADD.D with rs1=0x3FF0000000000000, rs2=0x4000000000000000, rd=5, rsp_ready=1.
  - Required response: req0_ready high in cycle T; rsp_valid first high at T+3.
  - Response fields: rsp_result=0x7FF0000000000000, rsp_id=0, rsp_rd=5, rsp_illegal=0.
- **Contention.** Both requesters valid continuously with FMUL.D, starting from reset.
  - Required grant order: 0,1,0,1.
  - Each rsp_valid comes 5 cycles after its accept.
  - The next accept comes 1 cycle after each response handshake.
- **Illegal op.** req1 funct3=3'b101, rd=9.
  - Required response: rsp_valid at T+1 with rsp_illegal=1, rsp_result=0, rsp_id=1, rsp_rd=9.
  - busy is high for exactly 1 cycle.
- **Backpressure.** FDIV.D accepted with rsp_ready=0 for 20 cycles.
  - rsp_valid goes high at T+17 and stays high with stable fields.
  - Both readys stay 0 despite pending requests.
  - The response clears on the cycle after rsp_ready rises.
- **Reset mid-EXEC.** Assert rst at T+8 of an FDIV.D.
  - All outputs read their reset values on the next cycle and rr=0.
  - No rsp_valid appears afterwards.
  - A new req0 FSUB.D is then serviced with normal latency.
- **Operand stability.** Change reqN_rs1 every cycle during EXEC.
  - fpu_rs1 and rsp_result reflect only the operands captured at accept.

Source files
------------

// File: rtl/fpu_d_sched.sv
// Round-robin scheduler sharing one combinational double-precision FPU between two requesters.
// The winning operation's operands are held stable on the FPU inputs for a per-op settle window.
module fpu_d_sched #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_rs1,
    input  logic [63:0] req0_rs2,
    input  logic [2:0]  req0_funct3,
    input  logic [4:0]  req0_rd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_rs1,
    input  logic [63:0] req1_rs2,
    input  logic [2:0]  req1_funct3,
    input  logic [4:0]  req1_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [4:0]  rsp_rd,
    output logic [63:0] rsp_result,
    output logic        rsp_illegal,
    output logic [63:0] fpu_rs1,
    output logic [63:0] fpu_rs2,
    output logic [2:0]  fpu_funct3,
    input  logic [63:0] fpu_result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [7:0] CNT_ADD = 8'(LAT_ADD - 1);
    localparam logic [7:0] CNT_MUL = 8'(LAT_MUL - 1);
    localparam logic [7:0] CNT_DIV = 8'(LAT_DIV - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] rs1_q, rs1_d;
    logic [63:0] rs2_q, rs2_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        id_q, id_d;
    logic [63:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    logic        grant0, grant1;
    logic [2:0]  sel_f3;

    function automatic logic [7:0] settle_load(input logic [2:0] f3);
        case (f3[1:0])
            2'b00, 2'b01: settle_load = CNT_ADD;
            2'b10:        settle_load = CNT_MUL;
            default:      settle_load = CNT_DIV;
        endcase
    endfunction

    // rr names the requester that wins when both are valid
    assign grant0 = req0_valid & (~req1_valid | ~rr_q);
    assign grant1 = req1_valid & (~req0_valid | rr_q);
    assign sel_f3 = grant1 ? req1_funct3 : req0_funct3;

    assign req0_ready  = (state_q == IDLE) & grant0;
    assign req1_ready  = (state_q == IDLE) & grant1;
    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign rsp_id      = id_q;
    assign rsp_rd      = rd_q;
    assign rsp_result  = result_q;
    assign rsp_illegal = illegal_q;
    assign fpu_rs1     = rs1_q;
    assign fpu_rs2     = rs2_q;
    assign fpu_funct3  = f3_q;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        id_d      = id_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    rr_d  = grant0;
                    id_d  = grant1;
                    rs1_d = grant1 ? req1_rs1 : req0_rs1;
                    rs2_d = grant1 ? req1_rs2 : req0_rs2;
                    rd_d  = grant1 ? req1_rd : req0_rd;
                    f3_d  = sel_f3;
                    if (sel_f3[2]) begin
                        // Unsupported op skips the FPU entirely
                        state_d   = RESP;
                        illegal_d = 1'b1;
                        result_d  = 64'd0;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = settle_load(sel_f3);
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 8'd0) begin
                    result_d  = fpu_result;
                    illegal_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cnt_q     <= 8'd0;
            rs1_q     <= 64'd0;
            rs2_q     <= 64'd0;
            f3_q      <= 3'd0;
            rd_q      <= 5'd0;
            id_q      <= 1'b0;
            result_q  <= 64'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            id_q      <= id_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
